// File: rtl/alu_writeback_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_writeback_pkg : shared types and constants for ALU writeback
// Rev 1.0
// ------------------------------------------------------------------
package alu_writeback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] PC_ADDR = 4'd15;

endpackage : alu_writeback_pkg
`default_nettype wire

// File: rtl/alu_writeback_cond_eval.sv
`default_nettype none
// ------------------------------------------------------------------
// cond_eval : combinational condition-code check against NZCV
// Rev 1.0
// ------------------------------------------------------------------
module cond_eval
  import alu_writeback_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic w_n, w_z, w_c, w_v;
  assign w_n = flags_i[FLAG_N];
  assign w_z = flags_i[FLAG_Z];
  assign w_c = flags_i[FLAG_C];
  assign w_v = flags_i[FLAG_V];

  always_comb begin
    pass_o = 1'b1;
    case (cond_i)
      COND_EQ: pass_o = w_z;
      COND_NE: pass_o = ~w_z;
      COND_CS: pass_o = w_c;
      COND_CC: pass_o = ~w_c;
      COND_MI: pass_o = w_n;
      COND_PL: pass_o = ~w_n;
      COND_VS: pass_o = w_v;
      COND_VC: pass_o = ~w_v;
      COND_HI: pass_o = w_c & ~w_z;
      COND_LS: pass_o = ~w_c | w_z;
      COND_GE: pass_o = (w_n == w_v);
      COND_LT: pass_o = (w_n != w_v);
      COND_GT: pass_o = ~w_z & (w_n == w_v);
      COND_LE: pass_o = w_z | (w_n != w_v);
      default: pass_o = 1'b1;  // AL, and NV treated as always
    endcase
  end

endmodule : cond_eval
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// ------------------------------------------------------------------
// alu_writeback : condition check, NZCV update and 1-2 cycle writeback
// Rev 1.0
// ------------------------------------------------------------------
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [3:0]        cond,
  input  logic              s_bit,
  input  logic              no_write,
  input  logic              long_mul,
  input  logic              alu_arith,
  input  logic [DATA_W-1:0] result_lo,
  input  logic [DATA_W-1:0] result_hi,
  input  logic [3:0]        alu_flags,
  input  logic [RA_W-1:0]   rd_lo,
  input  logic [RA_W-1:0]   rd_hi,
  output logic              reg_we,
  output logic [RA_W-1:0]   reg_wa,
  output logic [DATA_W-1:0] reg_wd,
  output logic              pc_we,
  output logic              cond_ex,
  output logic [3:0]        flags
);

  wb_state_e           state_q, state_d;
  logic [3:0]          flags_q, flags_d;
  logic                cond_q, long_q, no_write_q;
  logic [DATA_W-1:0]   lo_q, hi_q;
  logic [RA_W-1:0]     rd_lo_q, rd_hi_q;
  logic                w_pass, w_accept;

  cond_eval u_cond_eval (
    .cond_i  (cond),
    .flags_i (flags_q),
    .pass_o  (w_pass)
  );

  assign ready_out = (state_q == IDLE) | ((state_q == WR_LO) & ~long_q) | (state_q == WR_HI);
  assign w_accept  = valid_in & ready_out;
  assign flags     = flags_q;
  assign cond_ex   = cond_q;

  always_comb begin
    state_d = IDLE;
    if (w_accept)
      state_d = WR_LO;
    else if ((state_q == WR_LO) && long_q)
      state_d = WR_HI;
  end

  always_comb begin
    flags_d = flags_q;
    if (w_accept && w_pass && s_bit) begin
      if (long_mul) begin
        flags_d[FLAG_N] = result_hi[DATA_W-1];
        flags_d[FLAG_Z] = (result_hi == '0) && (result_lo == '0);
      end else begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (alu_arith) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      flags_q    <= 4'b0000;
      cond_q     <= 1'b0;
      long_q     <= 1'b0;
      no_write_q <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      rd_lo_q    <= '0;
      rd_hi_q    <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (w_accept) begin
        cond_q     <= w_pass;
        long_q     <= long_mul;
        no_write_q <= no_write;
        lo_q       <= result_lo;
        hi_q       <= result_hi;
        rd_lo_q    <= rd_lo;
        rd_hi_q    <= rd_hi;
      end
    end
  end

  // Enables decode only registered state; reset masks a write caught mid-flight.
  always_comb begin
    reg_we = 1'b0;
    pc_we  = 1'b0;
    reg_wa = '0;
    reg_wd = '0;
    case (state_q)
      WR_LO: begin
        reg_wa = rd_lo_q;
        reg_wd = lo_q;
        if (cond_q && !no_write_q && !reset) begin
          if (rd_lo_q == RA_W'(PC_ADDR)) pc_we  = 1'b1;
          else                           reg_we = 1'b1;
        end
      end
      WR_HI: begin
        reg_wa = rd_hi_q;
        reg_wd = hi_q;
        if (cond_q && !reset && (rd_hi_q != RA_W'(PC_ADDR)))
          reg_we = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : alu_writeback
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_writeback : vector table + write scoreboard for alu_writeback
// Rev 1.0
// ------------------------------------------------------------------
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready_out;
  logic [3:0]  cond;
  logic        s_bit, no_write, long_mul, alu_arith;
  logic [31:0] result_lo, result_hi;
  logic [3:0]  alu_flags;
  logic [3:0]  rd_lo, rd_hi;
  logic        reg_we, pc_we, cond_ex;
  logic [3:0]  reg_wa;
  logic [31:0] reg_wd;
  logic [3:0]  flags;

  alu_writeback #(.DATA_W(32), .RA_W(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .cond(cond), .s_bit(s_bit), .no_write(no_write), .long_mul(long_mul),
    .alu_arith(alu_arith), .result_lo(result_lo), .result_hi(result_hi),
    .alu_flags(alu_flags), .rd_lo(rd_lo), .rd_hi(rd_hi),
    .reg_we(reg_we), .reg_wa(reg_wa), .reg_wd(reg_wd), .pc_we(pc_we),
    .cond_ex(cond_ex), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cond;
    logic        s, nw, lm, ar;
    logic [31:0] lo, hi;
    logic [3:0]  af, rdl, rdh;
    logic [3:0]  exp_flags;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        we, pc;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  fl;
    logic        cx;
  } exp_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;
  logic [3:0] mf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic cpass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cc;
      4'h3: return !cc;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cc && !z;
      4'h9: return !cc || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Scoreboard consumer: any write cycle not predicted must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("reg_we", {31'b0, reg_we}, {31'b0, e.we});
        chk("pc_we", {31'b0, pc_we}, {31'b0, e.pc});
        if (e.we) chk("reg_wa", {28'b0, reg_wa}, {28'b0, e.wa});
        if (e.we || e.pc) chk("reg_wd", reg_wd, e.wd);
        chk("flags", {28'b0, flags}, {28'b0, e.fl});
        chk("cond_ex", {31'b0, cond_ex}, {31'b0, e.cx});
      end else begin
        chk("idle_we", {30'b0, reg_we, pc_we}, 32'd0);
      end
    end
  end

  task automatic drive(input vec_t v);
    cond = v.cond; s_bit = v.s; no_write = v.nw; long_mul = v.lm; alu_arith = v.ar;
    result_lo = v.lo; result_hi = v.hi; alu_flags = v.af; rd_lo = v.rdl; rd_hi = v.rdh;
    valid_in = 1'b1;
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic p;
    int   w;

    //          cond  s     nw    lm    ar    lo            hi            af     rdl    rdh    flags
    vecs[0]  = '{4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        4'b0110, 4'd3,  4'd0,  4'b0110};
    vecs[1]  = '{4'hE, 1'b1, 1'b0, 1'b0, 1'b1, 32'h11,       32'h0,        4'b0011, 4'd4,  4'd0,  4'b0011};
    vecs[2]  = '{4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22,       32'h0,        4'b1000, 4'd5,  4'd0,  4'b1011};
    vecs[3]  = '{4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 4'b0100, 4'd1,  4'd2,  4'b1011};
    vecs[4]  = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h55,       32'h0,        4'b0100, 4'd5,  4'd0,  4'b1011};
    vecs[5]  = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h66,       32'h0,        4'b0000, 4'd6,  4'd0,  4'b1011};
    vecs[6]  = '{4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100,      32'h0,        4'b0000, 4'd15, 4'd0,  4'b1011};
    vecs[7]  = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77,       32'h0,        4'b0110, 4'd7,  4'd0,  4'b0110};
    vecs[8]  = '{4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h88,       32'h99,       4'b1111, 4'd7,  4'd8,  4'b0110};
    vecs[9]  = '{4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1,        32'h2,        4'b0000, 4'd9,  4'd9,  4'b0110};
    vecs[10] = '{4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3,        32'h4,        4'b0000, 4'd10, 4'd15, 4'b0110};
    vecs[11] = '{4'h2, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAB,       32'h0,        4'b1001, 4'd11, 4'd0,  4'b1001};
    vecs[12] = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        4'b1111, 4'd12, 4'd13, 4'b0101};
    vecs[13] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hEE,       32'h0,        4'b0000, 4'd14, 4'd0,  4'b0101};
    vecs[14] = '{4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234,     32'h0,        4'b0000, 4'd0,  4'd0,  4'b0101};
    vecs[15] = '{4'hC, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5678,     32'h0,        4'b0000, 4'd2,  4'd0,  4'b0101};

    reset = 1'b1; valid_in = 1'b0;
    cond = 4'h0; s_bit = 1'b0; no_write = 1'b0; long_mul = 1'b0; alu_arith = 1'b0;
    result_lo = '0; result_hi = '0; alu_flags = '0; rd_lo = '0; rd_hi = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_ready", {31'b0, ready_out}, 32'd1);
    chk("rst_we", {30'b0, reg_we, pc_we}, 32'd0);
    chk("rst_wa", {28'b0, reg_wa}, 32'd0);
    chk("rst_wd", reg_wd, 32'd0);
    chk("rst_cond_ex", {31'b0, cond_ex}, 32'd0);
    reset = 1'b0;
    mf = 4'b0000;

    // Back-to-back table: each op issued as soon as ready_out allows.
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      drive(v);
      w = 0;
      while (!ready_out && w < 8) begin
        @(negedge clk);
        w++;
      end
      if (!ready_out) chk("ready_timeout", 32'd0, 32'd1);
      p = cpass(v.cond, mf);
      e.cyc = cyc + 1;
      e.we  = p && !v.nw && (v.rdl != 4'd15);
      e.pc  = p && !v.nw && (v.rdl == 4'd15);
      e.wa  = v.rdl; e.wd = v.lo; e.fl = v.exp_flags; e.cx = p;
      q.push_back(e);
      if (v.lm) begin
        e.cyc = cyc + 2;
        e.we  = p && (v.rdh != 4'd15);
        e.pc  = 1'b0;
        e.wa  = v.rdh; e.wd = v.hi;
        q.push_back(e);
      end
      mf = v.exp_flags;
      @(negedge clk);
    end
    valid_in = 1'b0;
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("drain", q.size(), 32'd0);
    @(negedge clk);
    mon_en = 1'b0;

    // Reset mid-operation: long multiply aborted in its lo cycle.
    v = '{4'hE, 1'b1, 1'b0, 1'b1, 1'b1, 32'h5, 32'h80000000, 4'b0011, 4'd4, 4'd6, 4'b0000};
    drive(v);
    @(negedge clk);
    valid_in = 1'b0;
    chk("mid_flags_upd", {28'b0, flags}, {28'b0, 4'b1011});
    reset = 1'b1;
    #1;
    chk("mid_rst_cycle_we", {30'b0, reg_we, pc_we}, 32'd0);
    @(negedge clk);
    chk("mid_rst_flags", {28'b0, flags}, 32'd0);
    chk("mid_rst_ready", {31'b0, ready_out}, 32'd1);
    chk("mid_rst_we", {30'b0, reg_we, pc_we}, 32'd0);
    chk("mid_rst_cond_ex", {31'b0, cond_ex}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_we", {30'b0, reg_we, pc_we}, 32'd0);
    chk("post_rst_ready", {31'b0, ready_out}, 32'd1);

    // valid_in held while busy must not start a second op early.
    v = '{4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA, 32'hB, 4'b0000, 4'd1, 4'd2, 4'b0000};
    drive(v);
    @(negedge clk);
    chk("busy_ready", {31'b0, ready_out}, 32'd0);
    chk("busy_lo_wd", reg_wd, 32'hA);
    v.lo = 32'hC; v.lm = 1'b0; v.rdl = 4'd3;
    drive(v);
    @(negedge clk);
    chk("busy_hi_wd", reg_wd, 32'hB);
    chk("busy_hi_wa", {28'b0, reg_wa}, 32'd2);
    @(negedge clk);
    valid_in = 1'b0;
    chk("next_lo_wd", reg_wd, 32'hC);
    chk("next_lo_wa", {28'b0, reg_wa}, 32'd3);
    chk("next_lo_we", {31'b0, reg_we}, 32'd1);
    @(negedge clk);
    chk("final_idle_we", {30'b0, reg_we, pc_we}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_writeback
`default_nettype wire
